// File: rtl/ux607_uart_pkg.sv
// Constants and types shared by the UART transmitter and receiver.
package ux607_uart_pkg;

  localparam logic UART_START     = 1'b0;
  localparam logic UART_STOP      = 1'b1;
  localparam int   UART_DATA_W    = 8;
  localparam int   UART_FRAME_LEN = 10;
  localparam int   UART_BITCNT_W  = 4;

  typedef enum logic {
    UART_IDLE  = 1'b0,
    UART_SHIFT = 1'b1
  } uart_state_e;

  // Bits on the wire for one frame: start + data + one or two stop bits.
  function automatic logic [UART_BITCNT_W-1:0] uart_frame_bits(input logic nstop);
    return UART_BITCNT_W'(UART_FRAME_LEN) + UART_BITCNT_W'(nstop);
  endfunction

endpackage

// File: rtl/ux607_uart_baud_gen.sv
// Baud prescaler: down-counter that ticks at zero and reloads; load sets a start offset.
module ux607_uart_baud_gen
  import ux607_uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en & ~load & (cnt_q == '0);

  // Reload samples reload_val only at zero, so a divisor change lands on the next bit.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? reload_val : cnt_q - DIV_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous reset;
  // all next-state logic lives in always_comb with a default first, so no latches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ux607_uart_tx.sv
// UART transmitter: pulls bytes from the TX queue and shifts them out as 8N1/8N2 frames.
module ux607_uart_tx
  import ux607_uart_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_en,
  input  logic [DIV_W-1:0]  io_div,
  input  logic              io_nstop,
  output logic              io_in_ready,
  input  logic              io_in_valid,
  input  logic [DATA_W-1:0] io_in_bits,
  output logic              io_out,
  output logic              io_busy
);

  localparam int SHIFT_W = DATA_W + 3;

  uart_state_e              state_q, state_d;
  logic [SHIFT_W-1:0]       shifter_q, shifter_d;
  logic [UART_BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic                     out_q, out_d;
  logic                     busy_q, busy_d;
  logic                     in_shift;
  logic                     accept;
  logic                     tick;

  assign in_shift    = (state_q == UART_SHIFT);
  // Held low during reset so the queue is never popped while the block is being cleared.
  assign io_in_ready = io_en & ~in_shift & ~reset;
  assign accept      = io_in_valid & io_in_ready;
  assign io_out      = out_q;
  assign io_busy     = busy_q;

  ux607_uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_val   (io_div),
    .en         (in_shift),
    .reload_val (io_div),
    .tick       (tick)
  );

  always_comb begin
    state_d   = state_q;
    shifter_d = shifter_q;
    bitcnt_d  = bitcnt_q;
    out_d     = out_q;
    busy_d    = busy_q;
    if (accept) begin
      shifter_d = {(io_nstop ? 2'b11 : 2'b01), io_in_bits, UART_START};
      bitcnt_d  = uart_frame_bits(io_nstop);
      out_d     = UART_START;
      busy_d    = 1'b1;
      state_d   = UART_SHIFT;
    end else if (tick) begin
      shifter_d = {UART_STOP, shifter_q[SHIFT_W-1:1]};
      bitcnt_d  = bitcnt_q - UART_BITCNT_W'(1);
      if (bitcnt_q == UART_BITCNT_W'(1)) begin
        // Last stop bit done: line returns to idle-high regardless of the frame's tail.
        out_d   = UART_STOP;
        busy_d  = 1'b0;
        state_d = UART_IDLE;
      end else begin
        out_d = shifter_d[0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= UART_IDLE;
      shifter_q <= '1;
      bitcnt_q  <= '0;
      out_q     <= UART_STOP;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shifter_q <= shifter_d;
      bitcnt_q  <= bitcnt_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
    end
  end

endmodule
